// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-lite constants, slave state encoding and transfer helpers.
// Holds HTRANS/HSIZE/HRESP codes, state enum, lane mask and legality decode.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    function automatic logic size_illegal(logic [2:0] size, logic [1:0] a);
        logic bad;
        bad = 1'b0;
        unique case (1'b1)
            size > HSIZE_WORD:  bad = 1'b1;
            size == HSIZE_HALF: bad = a[0];
            size == HSIZE_WORD: bad = (a != 2'b00);
            default:            bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Little-endian lanes: byte 0 lives in bits [7:0].
    function automatic logic [3:0] lane_mask(logic [2:0] size, logic [1:0] a);
        logic [3:0] m;
        m = 4'b1111;
        unique case (1'b1)
            size == HSIZE_BYTE: m = 4'b0001 << a;
            size == HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default:            m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite slave-side bus bundle.
// master: fabric drives address/control/HWDATA/HREADY; slave: HRDATA/HREADYOUT/HRESP.
interface ahb_sram_slave_if;
    import ahb_lite_pkg::*;

    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );

endinterface

// File: rtl/ahb_sram_bytelane_mem.sv
// 2^ADDR_WIDTH x 32 storage with byte-enable synchronous write, async read.
// Ports: clk, we, be[3:0], addr (word), wdata, rdata.
module ahb_sram_bytelane_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite SRAM slave with WAIT_STATES wait cycles and two-cycle ERROR.
// Ports: clk, reset (sync, active-high), bus (ahb_sram_slave_if.slave).
module ahb_sram_slave
    import ahb_lite_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    ahb_sram_slave_if.slave   bus
);

    localparam int AW = ADDR_WIDTH + 2;
    localparam logic [7:0] CNT_LOAD = 8'(WAIT_STATES - 1);

    slv_state_e    state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic [AW-1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;

    logic          open_ok;
    logic          accept;
    logic          bad;
    logic          mem_we;
    logic [31:0]   mem_rdata;

    // New address phases are only sampled while our own HREADYOUT is high.
    assign open_ok = (state == ST_IDLE) || (state == ST_DATA) ||
                     (state == ST_ERR2);
    assign accept  = open_ok && bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign bad     = size_illegal(bus.HSIZE, bus.HADDR[1:0]);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            ST_WAIT: begin
                if (cnt == 8'd0) begin
                    state_n = ST_DATA;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            ST_ERR1: state_n = ST_ERR2;
            default: begin
                state_n = ST_IDLE;
                if (accept) begin
                    if (bad) begin
                        state_n = ST_ERR1;
                    end else if (WAIT_STATES == 0) begin
                        state_n = ST_DATA;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = CNT_LOAD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q  <= bus.HADDR[AW-1:0];
                write_q <= bus.HWRITE;
                size_q  <= bus.HSIZE;
            end
        end
    end

    // Commit at the edge closing DATA; a reset on that edge drops it.
    assign mem_we = (state == ST_DATA) && write_q && !reset;

    ahb_sram_bytelane_mem #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (lane_mask(size_q, addr_q[1:0])),
        .addr  (addr_q[AW-1:2]),
        .wdata (bus.HWDATA),
        .rdata (mem_rdata)
    );

    assign bus.HREADYOUT = !((state == ST_WAIT) || (state == ST_ERR1));
    assign bus.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ?
                           HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = ((state == ST_DATA) && !write_q) ?
                           mem_rdata : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{bus.HADDR[31:AW], bus.HTRANS[0], bus.HBURST};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one WAIT_STATES=1 and one WAIT_STATES=0 instance.
// Pipelined master, scoreboard queue, immediate assertions on completions.
module tb_ahb_sram_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          sel = 1;
    logic        hsel_a = 1'b0;
    logic [31:0] haddr = '0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [2:0]  hsize = 3'b000;
    logic [2:0]  hburst = 3'b000;
    logic [31:0] hwdata = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ahb_sram_slave_if bus0 ();
    ahb_sram_slave_if bus1 ();

    assign bus0.HSEL   = hsel_a && (sel == 0);
    assign bus0.HADDR  = haddr;
    assign bus0.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;
    assign bus0.HBURST = hburst;
    assign bus0.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;

    assign bus1.HSEL   = hsel_a && (sel == 1);
    assign bus1.HADDR  = haddr;
    assign bus1.HTRANS = htrans;
    assign bus1.HWRITE = hwrite;
    assign bus1.HSIZE  = hsize;
    assign bus1.HBURST = hburst;
    assign bus1.HWDATA = hwdata;
    assign bus1.HREADY = bus1.HREADYOUT;

    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    ahb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } exp_t;

    cmd_t        cq[$];
    exp_t        sb[$];
    bit   [31:0] model [int];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic push(logic wr, logic [31:0] a, logic [2:0] sz,
                        logic [1:0] tr, logic [31:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.size = sz; c.trans = tr; c.wdata = d;
        cq.push_back(c);
    endtask

    function automatic exp_t predict(cmd_t c);
        exp_t e;
        int key;
        logic [3:0] be;
        bit [31:0] w;
        e.rd = !c.wr;
        e.data = 32'h0;
        e.err = (c.size > 3'd2) ||
                (c.size == 3'd1 && c.addr[0]) ||
                (c.size == 3'd2 && c.addr[1:0] != 2'b00);
        key = sel * 4096 + int'(c.addr[11:2]);
        if (!e.err) begin
            if (c.size == 3'd0) be = 4'b0001 << c.addr[1:0];
            else if (c.size == 3'd1) be = c.addr[1] ? 4'b1100 : 4'b0011;
            else be = 4'b1111;
            w = model.exists(key) ? model[key] : 32'h0;
            if (c.wr) begin
                for (int i = 0; i < 4; i++)
                    if (be[i]) w[8*i +: 8] = c.wdata[8*i +: 8];
                model[key] = w;
            end else begin
                e.data = w;
            end
        end
        return e;
    endfunction

    // Runs the queued commands as a pipelined master; entered at posedge+1.
    task automatic run(string tag);
        cmd_t ap, dp;
        exp_t e;
        bit ap_v, dp_v;
        logic rdy, rsp;
        logic [31:0] rd;
        int waits, guard, ws, n;
        ap_v = 0; dp_v = 0; waits = 0; guard = 0; n = 0;
        ws = (sel == 1) ? 1 : 0;
        if (cq.size() > 0) begin ap = cq.pop_front(); ap_v = 1; end
        while ((ap_v || dp_v) && guard < 200) begin
            hsel_a = ap_v;
            haddr  = ap_v ? ap.addr : 32'h0;
            htrans = ap_v ? ap.trans : 2'b00;
            hwrite = ap_v ? ap.wr : 1'b0;
            hsize  = ap_v ? ap.size : 3'b000;
            hburst = (ap_v && ap.trans == 2'b11) ? 3'b001 : 3'b000;
            hwdata = dp_v ? dp.wdata : 32'h0;
            @(negedge clk);
            rdy = (sel == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
            rsp = (sel == 1) ? bus1.HRESP : bus0.HRESP;
            rd  = (sel == 1) ? bus1.HRDATA : bus0.HRDATA;
            if (dp_v) begin
                if (!rdy) begin
                    waits++;
                end else begin
                    n++;
                    e = sb.pop_front();
                    check($sformatf("%s#%0d resp", tag, n), 32'(rsp), 32'(e.err));
                    check($sformatf("%s#%0d waits", tag, n), waits,
                          e.err ? 1 : ws);
                    check($sformatf("%s#%0d hrdata", tag, n), rd, e.data);
                    dp_v = 0;
                end
            end
            if (rdy && ap_v) begin
                dp = ap; dp_v = 1; waits = 0;
                sb.push_back(predict(ap));
                ap_v = 0;
                if (cq.size() > 0) begin ap = cq.pop_front(); ap_v = 1; end
            end
            @(posedge clk); #1;
            guard++;
        end
        check({tag, " timeout"}, 32'(guard < 200), 32'd1);
        hsel_a = 1'b0; htrans = 2'b00; hwdata = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst1 ready", 32'(bus1.HREADYOUT), 32'd1);
        check("rst1 resp", 32'(bus1.HRESP), 32'd0);
        check("rst1 hrdata", bus1.HRDATA, 32'h0);
        check("rst0 ready", 32'(bus0.HREADYOUT), 32'd1);
        check("rst0 resp", 32'(bus0.HRESP), 32'd0);
        check("rst0 hrdata", bus0.HRDATA, 32'h0);
        @(posedge clk); #1;

        sel = 1;
        hsel_a = 1'b1; htrans = 2'b00; haddr = 32'h10;
        @(negedge clk);
        @(posedge clk); #1;
        hsel_a = 1'b0;
        @(negedge clk);
        check("idle ready", 32'(bus1.HREADYOUT), 32'd1);
        check("idle resp", 32'(bus1.HRESP), 32'd0);
        @(posedge clk); #1;

        push(1, 32'h10, 3'd2, 2'b10, 32'hDEADBEEF);
        push(0, 32'h10, 3'd2, 2'b10, 32'h0);
        run("ws1_word");

        push(1, 32'h20, 3'd2, 2'b10, 32'h11223344);
        push(1, 32'h21, 3'd0, 2'b10, 32'h0000AA00);
        push(1, 32'h22, 3'd1, 2'b10, 32'h55660000);
        push(0, 32'h20, 3'd2, 2'b10, 32'h0);
        run("lanes");
        check("lanes model", model[4096 + 8], 32'h5566AA44);

        push(1, 32'h04, 3'd2, 2'b10, 32'h0BADF00D);
        push(1, 32'h06, 3'd2, 2'b10, 32'hFFFFFFFF);
        push(1, 32'h04, 3'd3, 2'b10, 32'hFFFFFFFF);
        push(1, 32'h05, 3'd1, 2'b10, 32'hFFFFFFFF);
        push(0, 32'h04, 3'd2, 2'b10, 32'h0);
        run("err");

        sel = 0;
        push(1, 32'h0, 3'd2, 2'b10, 32'hA0A0A0A0);
        push(1, 32'h4, 3'd2, 2'b11, 32'hB1B1B1B1);
        push(1, 32'h8, 3'd2, 2'b11, 32'hC2C2C2C2);
        push(0, 32'h0, 3'd2, 2'b10, 32'h0);
        push(0, 32'h4, 3'd2, 2'b11, 32'h0);
        push(0, 32'h8, 3'd2, 2'b11, 32'h0);
        push(1, 32'hC, 3'd2, 2'b10, 32'h13579BDF);
        push(0, 32'hC, 3'd2, 2'b10, 32'h0);
        run("ws0");

        sel = 1;
        push(1, 32'h30, 3'd2, 2'b10, 32'h01234567);
        push(0, 32'h30, 3'd2, 2'b10, 32'h0);
        run("pre_abort");

        hsel_a = 1'b1; htrans = 2'b10; hwrite = 1'b1;
        hsize = 3'd2; haddr = 32'h30;
        @(negedge clk);
        check("abort accept", 32'(bus1.HREADYOUT), 32'd1);
        @(posedge clk); #1;
        hsel_a = 1'b0; htrans = 2'b00; hwdata = 32'hCAFEF00D;
        @(negedge clk);
        check("abort wait", 32'(bus1.HREADYOUT), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        hwdata = 32'h0;
        @(negedge clk);
        check("abort ready", 32'(bus1.HREADYOUT), 32'd1);
        check("abort resp", 32'(bus1.HRESP), 32'd0);
        check("abort hrdata", bus1.HRDATA, 32'h0);
        @(posedge clk); #1;

        push(0, 32'h30, 3'd2, 2'b10, 32'h0);
        run("post_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
